// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and a saturating counter helper.
// Combinational only; no flow control.
// No backpressure.
package fifo_pkg;

    localparam int FIFO_DSIZE    = 8;
    localparam int FIFO_ADDRSIZE = 4;
    localparam int STAT_W        = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// Gray-code to binary pointer conversion.
// Combinational, zero latency.
// No backpressure.
module gray2bin #(
    parameter int width = 5
) (
    input  logic [width-1:0] gray_i,
    output logic [width-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < width; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: 2-entry skid buffer, level/almost-full, stats under FIFO_WR_STATS_EN.
// Latency: a word accepted in cycle N can drive winc in cycle N+1; wlevel/walmost_full lag pointers by 1.
// Backpressure: s_ready registered, drops while two words are held behind wfull; wflush discards them.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DSIZE        = FIFO_DSIZE,
    parameter int ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    input  logic                wflush,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic [STAT_W-1:0]   wr_cnt,
    output logic [STAT_W-1:0]   stall_cnt
);

    localparam int LVL_W = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AFULL_TH = LVL_W'((1 << ADDRSIZE) - AFULL_MARGIN);

    logic [1:0]          bcnt_q, bcnt_d;
    logic [DSIZE-1:0]    buf0_q, buf0_d;
    logic [DSIZE-1:0]    buf1_q, buf1_d;
    logic                s_ready_q, s_ready_d;
    logic [ADDRSIZE:0]   wlevel_q, wlevel_d;
    logic                afull_q, afull_d;
    logic [ADDRSIZE:0]   wbin, rbin;
    logic                accept, issue;

    gray2bin #(.width(LVL_W)) u_wptr_bin (.gray_i(wptr),     .bin_o(wbin));
    gray2bin #(.width(LVL_W)) u_rptr_bin (.gray_i(wq2_rptr), .bin_o(rbin));

    assign accept = s_valid & s_ready_q;
    assign issue  = (bcnt_q != 2'd0) & ~wfull & ~wflush;

    // buf0 is always the head; an issue shifts buf1 forward before any new word lands.
    always_comb begin
        bcnt_d = bcnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (issue) begin
            buf0_d = buf1_q;
        end
        if (wflush) begin
            bcnt_d = 2'd0;
        end else begin
            bcnt_d = bcnt_q + {1'b0, accept} - {1'b0, issue};
            if (accept) begin
                if (bcnt_d == 2'd1) begin
                    buf0_d = s_data;
                end else begin
                    buf1_d = s_data;
                end
            end
        end
        s_ready_d = (bcnt_d < 2'd2);
        wlevel_d  = wbin - rbin;
        afull_d   = (wlevel_d >= AFULL_TH);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            bcnt_q    <= 2'd0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            s_ready_q <= 1'b0;
            wlevel_q  <= '0;
            afull_q   <= 1'b0;
        end else begin
            bcnt_q    <= bcnt_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            s_ready_q <= s_ready_d;
            wlevel_q  <= wlevel_d;
            afull_q   <= afull_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign winc         = issue;
    assign wdata        = buf0_q;
    assign wlevel       = wlevel_q;
    assign walmost_full = afull_q;

`ifdef FIFO_WR_STATS_EN
    logic [STAT_W-1:0] wr_cnt_q;
    logic [STAT_W-1:0] stall_cnt_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
            if ((bcnt_q != 2'd0) && wfull) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign wr_cnt    = wr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign wr_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: skid-buffer scoreboard plus directed level, flush and reset cases.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        wflush = 1'b0;
    logic        wfull = 1'b0;
    logic [4:0]  wptr = '0;
    logic [4:0]  wq2_rptr = '0;
    logic        winc;
    logic [7:0]  wdata;
    logic [4:0]  wlevel;
    logic        walmost_full;
    logic [15:0] wr_cnt;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    bit         model_issue;
    bit         rdy_m;
    bit         rdy_known = 1'b0;
    int         exp_wr = 0;
    int         exp_stall = 0;

    fifo_wr_ctrl #(.DSIZE(8), .ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wflush(wflush), .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
        .winc(winc), .wdata(wdata), .wlevel(wlevel), .walmost_full(walmost_full),
        .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: the queue models the skid-buffer contents, sampled mid-cycle.
    always @(negedge wclk) begin
        if (!wrst_n) begin
            exp_q.delete();
            rdy_known = 1'b0;
            exp_wr    = 0;
            exp_stall = 0;
        end else begin
            if (rdy_known) chk("s_ready_model", 32'(s_ready), 32'(rdy_m));
            model_issue = (exp_q.size() != 0) && !wfull && !wflush;
            if ((exp_q.size() != 0) && wfull) exp_stall++;
            chk("winc_model", 32'(winc), 32'(model_issue));
            if (model_issue) begin
                exp_wr++;
                if (exp_q.size() != 0) chk("wdata", 32'(wdata), 32'(exp_q.pop_front()));
            end
            if (wflush) exp_q.delete();
            else if (s_valid && s_ready) exp_q.push_back(s_data);
            rdy_m     = (exp_q.size() < 2);
            rdy_known = 1'b1;
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_winc"},    32'(winc), 0);
        chk({tag, "_wdata"},   32'(wdata), 0);
        chk({tag, "_wlevel"},  32'(wlevel), 0);
        chk({tag, "_afull"},   32'(walmost_full), 0);
        chk({tag, "_wr_cnt"},  32'(wr_cnt), 0);
        chk({tag, "_stall"},   32'(stall_cnt), 0);
    endtask

    initial begin
        // Reset state, then first edge after release raises s_ready.
        #12;
        check_all_zero("reset");
        #10;
        wrst_n = 1'b1;
        #1;
        chk("pre_edge_s_ready", 32'(s_ready), 0);
        tick();
        chk("first_edge_s_ready", 32'(s_ready), 1);

        // Streaming 0x01..0x10 with wfull low.
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            #1;
            chk("stream_s_ready", 32'(s_ready), 1);
            chk("stream_winc", 32'(winc), (i > 1) ? 1 : 0);
            tick();
        end
        s_valid = 1'b0;
        #1;
        chk("stream_last_winc", 32'(winc), 1);
        chk("stream_last_wdata", 32'(wdata), 32'h10);
        tick();
        chk("stream_idle_winc", 32'(winc), 0);
        chk("stream_wr_cnt", 32'(wr_cnt), STATS ? 16 : 0);

        // Backpressure: bcnt=1 under wfull still takes one more word.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
        tick();
        s_data = 8'hA1;
        #1;
        chk("bp_s_ready_b", 32'(s_ready), 1);
        chk("bp_winc_b", 32'(winc), 0);
        tick();
        s_data = 8'hA2;
        #1;
        chk("bp_s_ready_c", 32'(s_ready), 0);
        chk("bp_winc_c", 32'(winc), 0);
        tick();
        tick();
        wfull = 1'b0; s_valid = 1'b0;
        #1;
        chk("bp_issue1", 32'(winc), 1);
        chk("bp_issue1_data", 32'(wdata), 32'hA0);
        chk("bp_s_ready_e", 32'(s_ready), 0);
        tick();
        chk("bp_issue2", 32'(winc), 1);
        chk("bp_issue2_data", 32'(wdata), 32'hA1);
        chk("bp_s_ready_f", 32'(s_ready), 1);
        tick();
        chk("bp_drained", 32'(winc), 0);
        chk("bp_stall_cnt", 32'(stall_cnt), STATS ? 3 : 0);
        chk("bp_wr_cnt", 32'(wr_cnt), STATS ? 18 : 0);

        // Level, almost-full and pointer wrap.
        wptr = 5'b01001; wq2_rptr = 5'b00000;
        #1;
        chk("af_before_edge", 32'(walmost_full), 0);
        tick();
        chk("lvl14", 32'(wlevel), 14);
        chk("af14", 32'(walmost_full), 1);
        wptr = 5'b01011;
        tick();
        chk("lvl13", 32'(wlevel), 13);
        chk("af13", 32'(walmost_full), 0);
        wptr = 5'b00011; wq2_rptr = 5'b10010;
        tick();
        chk("lvl_wrap", 32'(wlevel), 6);
        chk("af_wrap", 32'(walmost_full), 0);
        wptr = 5'b11000; wq2_rptr = 5'b00000;
        tick();
        chk("lvl_full", 32'(wlevel), 16);
        chk("af_full", 32'(walmost_full), 1);

        // Flush with two words held and a word offered.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB0;
        tick();
        s_data = 8'hB1;
        tick();
        wfull = 1'b0; wflush = 1'b1; s_data = 8'hB2;
        #1;
        chk("flush_winc", 32'(winc), 0);
        tick();
        wflush = 1'b0; s_valid = 1'b0;
        #1;
        chk("flush_s_ready", 32'(s_ready), 1);
        chk("flush_empty", 32'(winc), 0);
        // Flush also drops a same-cycle accept.
        s_valid = 1'b1; s_data = 8'hC0;
        tick();
        s_data = 8'hC1; wflush = 1'b1;
        #1;
        chk("flush2_winc", 32'(winc), 0);
        tick();
        wflush = 1'b0; s_valid = 1'b0;
        #1;
        chk("flush2_dropped", 32'(winc), 0);
        tick();

        // Reset mid-stream with two words buffered and a non-zero level.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hD0;
        tick();
        s_data = 8'hD1;
        tick();
        s_valid = 1'b0;
        #1;
        wrst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        wfull = 1'b0; wptr = '0;
        #2;
        wrst_n = 1'b1;
        tick();
        chk("postrst_s_ready", 32'(s_ready), 1);
        chk("postrst_winc", 32'(winc), 0);
        tick();
        chk("postrst_winc2", 32'(winc), 0);

        // Exactly three stalled cycles.
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hE0;
        tick();
        s_valid = 1'b0;
        tick(); tick(); tick();
        chk("stall3", 32'(stall_cnt), STATS ? 3 : 0);
        wfull = 1'b0;
        #1;
        chk("stall3_drain", 32'(winc), 1);
        tick();
        tick();

        chk("model_stall", 32'(stall_cnt), STATS ? 32'(exp_stall) : 0);
        chk("model_wr", 32'(wr_cnt), STATS ? 32'(exp_wr) : 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
